irq_priority_controller: RTL



---
 rtl/irq_priority_controller_pkg.sv | 20 ++
 rtl/irq_priority_controller_encoder.sv | 23 ++
 rtl/irq_priority_controller.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/irq_priority_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_priority_controller_pkg
// Description : Shared constants and FSM state encoding for the 16-line
//               interrupt priority controller.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_priority_controller_pkg;

    localparam int IRQ_LINES = 16;
    localparam int ID_W      = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

endpackage : irq_priority_controller_pkg
`default_nettype wire

// File: rtl/irq_priority_controller_encoder.sv
`default_nettype none
// ============================================================================
// Module      : Encoder_16
// Description : 16-to-4 one-hot to binary index encoder. The input must be
//               one-hot or zero; zero encodes to index 0.
// Ports       : i_onehot [15:0] one-hot input vector
//               o_index  [3:0]  binary index of the set bit
// Revision    : 1.0 - initial release
// ============================================================================
module Encoder_16 (
    input  logic [15:0] i_onehot,
    output logic [3:0]  o_index
);

    // Each index bit is the OR of all input positions whose index has that
    // bit set; valid only because at most one input bit is high.
    assign o_index[0] = |(i_onehot & 16'hAAAA);
    assign o_index[1] = |(i_onehot & 16'hCCCC);
    assign o_index[2] = |(i_onehot & 16'hF0F0);
    assign o_index[3] = |(i_onehot & 16'hFF00);

endmodule : Encoder_16
`default_nettype wire

// File: rtl/irq_priority_controller.sv
`default_nettype none
// ============================================================================
// Module      : irq_priority_controller
// Description : 16-line interrupt controller. Lines are latched as edge- or
//               level-triggered, masked, and the lowest eligible line is
//               presented to the core via a req/ack/EOI handshake.
//               No nesting: one interrupt in flight at a time.
// Ports       : CLK         system clock
//               RESET       synchronous active-high reset
//               irq_lines   raw interrupt sources (synchronous to CLK)
//               mask_we     enable-mask write strobe
//               mask_wdata  new enable mask (1 = enabled)
//               mask_o      current enable mask
//               pending_o   current pending register
//               irq_req_o   interrupt request to the core
//               irq_id_o    index of the requested / in-service line
//               irq_ack_i   core claims the request
//               irq_eoi_i   core signals end of service
//               busy_o      high while an interrupt is in service
// Revision    : 1.0 - initial release
// ============================================================================
module irq_priority_controller
    import irq_priority_controller_pkg::*;
#(
    parameter logic [15:0] EDGE_LINES = 16'h0000,
    parameter logic [15:0] RESET_MASK = 16'h0000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [IRQ_LINES-1:0] irq_lines,
    input  logic                 mask_we,
    input  logic [IRQ_LINES-1:0] mask_wdata,
    output logic [IRQ_LINES-1:0] mask_o,
    output logic [IRQ_LINES-1:0] pending_o,
    output logic                 irq_req_o,
    output logic [ID_W-1:0]      irq_id_o,
    input  logic                 irq_ack_i,
    input  logic                 irq_eoi_i,
    output logic                 busy_o
);

    irq_state_t           r_state;
    irq_state_t           w_state_next;
    logic [IRQ_LINES-1:0] r_pending;
    logic [IRQ_LINES-1:0] r_lines_q;
    logic [IRQ_LINES-1:0] r_mask;
    logic [ID_W-1:0]      r_id;

    logic [IRQ_LINES-1:0] w_eligible;
    logic [IRQ_LINES-1:0] w_onehot;
    logic [ID_W-1:0]      w_sel_id;
    logic                 w_ack_take;
    logic                 w_id_load;
    logic [IRQ_LINES-1:0] w_clr;
    logic [IRQ_LINES-1:0] w_pending_next;

    // ------------------------------------------------------------------
    // Selection: isolate the lowest eligible line, then encode it.
    // ------------------------------------------------------------------
    assign w_eligible = r_pending & r_mask;
    assign w_onehot   = w_eligible & (~w_eligible + 16'd1);

    Encoder_16 u_encoder (
        .i_onehot (w_onehot),
        .o_index  (w_sel_id)
    );

    // ------------------------------------------------------------------
    // Pending update. Edge lines are sticky until acked; a fresh edge in
    // the ack cycle re-sets the bit (set wins). Level lines track input.
    // ------------------------------------------------------------------
    assign w_ack_take = (r_state == REQ) && irq_ack_i;
    assign w_clr      = {{(IRQ_LINES-1){1'b0}}, w_ack_take} << r_id;

    assign w_pending_next =
        (EDGE_LINES & ((irq_lines & ~r_lines_q) | (r_pending & ~w_clr))) |
        (~EDGE_LINES & irq_lines);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pending <= '0;
            r_lines_q <= '0;
            r_mask    <= RESET_MASK;
        end else begin
            r_pending <= w_pending_next;
            r_lines_q <= irq_lines;
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_id    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_id_load) begin
                r_id <= w_sel_id;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_id_load    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_eligible != '0) begin
                    w_id_load    = 1'b1;
                    w_state_next = REQ;
                end
            end
            REQ: begin
                // Mask/pending changes never withdraw an issued request;
                // ack takes precedence over a simultaneous eoi.
                if (irq_ack_i) begin
                    w_state_next = SERVICE;
                end
            end
            SERVICE: begin
                if (irq_eoi_i) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign irq_req_o = (r_state == REQ);
    assign busy_o    = (r_state == SERVICE);
    assign irq_id_o  = r_id;
    assign mask_o    = r_mask;
    assign pending_o = r_pending;

endmodule : irq_priority_controller
`default_nettype wire
